seven2hex_monitor: RTL and testbench
====================================

Name: seven2hex_monitor

Overview:
Receive-side monitor for the multiplexed 4-digit seven-segment display bus that shows the 16-bit half-precision adder result. It samples the segment lines and the digit enables, debounces each digit, and decodes every segment pattern back to a 4-bit nibble. When a full scan frame has been captured, it emits the reconstructed 16-bit hex word. It is used on-chip for self-check and by the verification bench as the display scoreboard.

Parameters:
STABLE_CYCLES, 4, consecutive identical registered samples required before a digit is captured (min 2)
TIMEOUT_CYCLES, 65535, cycles without any capture before a partial frame is discarded

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
seg  input  7  segment lines {a,b,c,d,e,f,g}, active-high, a = bit 6
an  input  4  digit enables, active-high, one-hot; an[3] = most significant nibble, an = 0 means blanking
hex_word  output  16  last reconstructed word
word_valid  output  1  one-cycle pulse when hex_word updates
digit_err  output  4  per-digit invalid-pattern flags for the last frame, valid with word_valid
anode_err  output  1  pulse for each cycle that the registered an has more than one bit set
timeout  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset, synchronous, rst_n = 0 sampled on a clk edge:
  - all outputs are 0;
  - capture mask, nibble and invalid stores, stability counter, timeout counter and input registers are cleared.
- Reset mid-frame discards all partial captures. No word_valid is produced until four fresh captures complete after reset.
- Input stage: seg and an are registered once as seg_q and an_q, along with previous copies seg_p and an_p.
- Stability counter:
  - Cleared to 0 when seg_q != seg_p, an_q != an_p, or an_q is not one-hot.
  - Otherwise it increments, saturating at STABLE_CYCLES-1.
- Capture:
  - Occurs on the edge at which the counter reaches STABLE_CYCLES-1.
  - Exactly one capture per stable window; no further capture until the counter clears.
  - Writes the decoded nibble and the invalid bit for digit idx = index of the set bit in an_q, and sets mask[idx].
  - A repeated capture of an already-masked digit overwrites that digit (latest wins).
- Decode table, seg -> nibble. Any other pattern decodes to nibble 0 with the invalid bit set.
  - 1111110 -> 0, 0110000 -> 1, 1101101 -> 2, 1111001 -> 3
  - 0110011 -> 4, 1011011 -> 5, 1011111 -> 6, 1110000 -> 7
  - 1111111 -> 8, 1110011 -> 9, 1110111 -> A, 0011111 -> B
  - 1001110 -> C, 0111101 -> D, 1001111 -> E, 1000111 -> F
- Frame completion:
  - Triggered when a capture makes mask = 1111, including the completing digit.
  - On the next edge: hex_word = {nib3, nib2, nib1, nib0}, digit_err = {inv3..inv0}, word_valid = 1 for exactly one cycle, and mask is cleared.
  - hex_word and digit_err hold until the next frame.
- Latency: a digit pattern held from cycle t is captured at edge t+STABLE_CYCLES. word_valid asserts one cycle after the final capture.
- anode_err: asserted in every cycle that an_q has popcount > 1. Such cycles also clear the stability counter. an_q = 0 clears the counter silently.
- Timeout:
  - The timeout counter clears on every capture and otherwise increments while mask != 0.
  - On reaching TIMEOUT_CYCLES: mask is cleared, timeout pulses for one cycle, and the counter clears.
  - While mask = 0 the counter is held at 0.
  - If a capture and a timeout coincide, the capture wins: the counter clears and there is no timeout.
- No internal counter wraps. The stability counter saturates, and the timeout counter is sized ceil(log2(TIMEOUT_CYCLES+1)).

Test Plan:
- Display 0x3C00 with STABLE_CYCLES=4: digits 3..0 each held 10 cycles, patterns 1111001, 1001110, 1111110, 1111110 -> one word_valid pulse, hex_word = 16'h3C00, digit_err = 4'b0000.
- Glitch: digit 2 pattern changes after 2 cycles, then settles on 0011111 for 6 cycles -> single capture of B; a frame of 3,B,0,1 -> hex_word = 16'h3B01.
- Invalid pattern 0000001 on digit 1 within a frame 7,F,?,E -> hex_word = 16'h7F0E, digit_err = 4'b0010.
- an = 4'b0011 held 8 cycles -> anode_err high for 8 cycles, no capture, mask unchanged; then a valid frame completes normally.
- TIMEOUT_CYCLES=100: capture digits 3 and 2, then blank for 150 cycles -> timeout pulses once, no word_valid; the next full frame of 1,2,3,4 -> hex_word = 16'h1234.
- Reset mid-frame: capture digits 3..1, drive rst_n = 0 for one edge, then capture digit 0 only -> no word_valid, all outputs 0; a full frame afterwards produces a normal word_valid.

Source files
------------

// File: rtl/seven2hex_monitor.sv
// seven2hex_monitor
// Receive-side monitor for a multiplexed 4-digit seven-segment display bus.
// It registers the segment and digit-enable lines and waits for each digit to
// hold steady for STABLE_CYCLES registered samples. It then decodes the
// pattern back to a nibble. Once all four digits have been captured, it
// publishes the reconstructed 16-bit word.
//
// Ports:
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   seg[6:0]   : segment lines {a,b,c,d,e,f,g}, active-high, a = bit 6
//   an[3:0]    : one-hot digit enables, an[3] = most significant nibble, 0 = blank
//   hex_word   : last reconstructed 16-bit word
//   word_valid : one-cycle pulse when hex_word updates
//   digit_err  : per-digit invalid-pattern flags of the last frame
//   anode_err  : high in every cycle that the registered an has >1 bit set
//   timeout    : one-cycle pulse when a partial frame is discarded
module seven2hex_monitor #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] hex_word,
    output logic        word_valid,
    output logic [3:0]  digit_err,
    output logic        anode_err,
    output logic        timeout
);

    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_PRE  = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [6:0]       seg_q, seg_p;
    logic [3:0]       an_q, an_p;
    logic [SW-1:0]    stab_cnt;
    logic [TW-1:0]    tout_cnt;
    logic [3:0]       mask;
    logic [3:0][3:0]  nib_store;
    logic [3:0]       inv_store;
    logic             frame_pending;

    logic             an_multi;
    logic             an_onehot;
    logic             stable;
    logic             capture;
    logic [1:0]       idx;
    logic [3:0]       dec_nib;
    logic             dec_inv;

    // an_q & (an_q - 1) is non-zero exactly when more than one bit is set.
    assign an_multi  = (an_q & (an_q - 4'd1)) != 4'd0;
    assign an_onehot = (an_q != 4'd0) && !an_multi;
    assign anode_err = an_multi;

    assign stable  = (seg_q == seg_p) && (an_q == an_p) && an_onehot;
    // Capture on the single edge where the counter steps up to its ceiling.
    assign capture = stable && (stab_cnt == STAB_PRE);

    always_comb begin
        idx = 2'd0;
        unique case (an_q)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        dec_nib = 4'h0;
        dec_inv = 1'b0;
        case (seg_q)
            7'b1111110: dec_nib = 4'h0;
            7'b0110000: dec_nib = 4'h1;
            7'b1101101: dec_nib = 4'h2;
            7'b1111001: dec_nib = 4'h3;
            7'b0110011: dec_nib = 4'h4;
            7'b1011011: dec_nib = 4'h5;
            7'b1011111: dec_nib = 4'h6;
            7'b1110000: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1110011: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b0011111: dec_nib = 4'hB;
            7'b1001110: dec_nib = 4'hC;
            7'b0111101: dec_nib = 4'hD;
            7'b1001111: dec_nib = 4'hE;
            7'b1000111: dec_nib = 4'hF;
            default:    dec_inv = 1'b1;
        endcase
    end

    // Input registers and the saturating stability counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q    <= '0;
            seg_p    <= '0;
            an_q     <= '0;
            an_p     <= '0;
            stab_cnt <= '0;
        end else begin
            seg_q <= seg;
            seg_p <= seg_q;
            an_q  <= an;
            an_p  <= an_q;
            if (!stable)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Capture stores, frame assembly and the partial-frame timeout.
    // A capture always takes priority over a timeout on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask          <= '0;
            nib_store     <= '0;
            inv_store     <= '0;
            frame_pending <= 1'b0;
            tout_cnt      <= '0;
            hex_word      <= '0;
            digit_err     <= '0;
            word_valid    <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            timeout    <= 1'b0;

            if (frame_pending) begin
                hex_word      <= nib_store;
                digit_err     <= inv_store;
                word_valid    <= 1'b1;
                frame_pending <= 1'b0;
            end

            if (capture) begin
                nib_store[idx] <= dec_nib;
                inv_store[idx] <= dec_inv;
                mask           <= mask | an_q;
                tout_cnt       <= '0;
                if ((mask | an_q) == 4'hF)
                    frame_pending <= 1'b1;
            end else if (frame_pending) begin
                mask     <= '0;
                tout_cnt <= '0;
            end else if (mask == 4'd0) begin
                tout_cnt <= '0;
            end else if (tout_cnt == TOUT_LAST) begin
                mask     <= '0;
                timeout  <= 1'b1;
                tout_cnt <= '0;
            end else begin
                tout_cnt <= tout_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven2hex_monitor.sv
// tb_seven2hex_monitor
// Directed bench for seven2hex_monitor (STABLE_CYCLES=4, TIMEOUT_CYCLES=100).
// It drives digit patterns on the negative edge and observes outputs on the
// negative edge. Every expected value is a hand-computed constant.
module tb_seven2hex_monitor;

    localparam int STABLE = 4;
    localparam int TOUT   = 100;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111;
    localparam logic [6:0] SB = 7'b0011111, SC = 7'b1001110, SD = 7'b0111101;
    localparam logic [6:0] SE = 7'b1001111, SF = 7'b1000111, SBAD = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] hex_word;
    logic        word_valid;
    logic [3:0]  digit_err;
    logic        anode_err;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drive_cyc = 0;
    int wv_cnt = 0, to_cnt = 0, ae_cnt = 0, wv_cyc = 0;
    logic [15:0] wv_word = '0;
    logic [3:0]  wv_err = '0;
    int wv0, to0, ae0;

    seven2hex_monitor #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .an        (an),
        .hex_word  (hex_word),
        .word_valid(word_valid),
        .digit_err (digit_err),
        .anode_err (anode_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts output pulses and latches the published word.
    always @(negedge clk) begin
        if (word_valid) begin
            wv_cnt  <= wv_cnt + 1;
            wv_cyc  <= cyc;
            wv_word <= hex_word;
            wv_err  <= digit_err;
        end
        if (timeout)   to_cnt <= to_cnt + 1;
        if (anode_err) ae_cnt <= ae_cnt + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_digit(input logic [3:0] a, input logic [6:0] s, input int n);
        an        = a;
        seg       = s;
        drive_cyc = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0);
        hold_digit(4'b1000, s3, 10);
        hold_digit(4'b0100, s2, 10);
        hold_digit(4'b0010, s1, 10);
        hold_digit(4'b0001, s0, 10);
        hold_digit(4'b0000, 7'd0, 6);
    endtask

    initial begin
        rst_n = 1'b0;
        an    = 4'b0000;
        seg   = 7'd0;
        repeat (3) @(negedge clk);
        check_output("reset_hex_word", 32'(hex_word), 32'h0);
        check_output("reset_word_valid", 32'(word_valid), 32'h0);
        check_output("reset_digit_err", 32'(digit_err), 32'h0);
        check_output("reset_anode_err", 32'(anode_err), 32'h0);
        check_output("reset_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain frame 0x3C00, including the final-digit latency.
        wv0 = wv_cnt;
        run_frame(S3, SC, S0, S0);
        check_output("f3c00_pulses", 32'(wv_cnt - wv0), 32'd1);
        check_output("f3c00_word", 32'(wv_word), 32'h3C00);
        check_output("f3c00_err", 32'(wv_err), 32'h0);
        check_output("f3c00_latency", 32'(wv_cyc - (drive_cyc - 10)), 32'd6);
        check_output("f3c00_hold", 32'(hex_word), 32'h3C00);

        // Glitch on digit 2 before it settles on B.
        wv0 = wv_cnt;
        hold_digit(4'b1000, S3, 10);
        hold_digit(4'b0100, S3, 2);
        hold_digit(4'b0100, SB, 6);
        hold_digit(4'b0010, S0, 10);
        hold_digit(4'b0001, S1, 10);
        hold_digit(4'b0000, 7'd0, 6);
        check_output("glitch_pulses", 32'(wv_cnt - wv0), 32'd1);
        check_output("glitch_word", 32'(wv_word), 32'h3B01);
        check_output("glitch_err", 32'(wv_err), 32'h0);

        // Invalid pattern on digit 1.
        wv0 = wv_cnt;
        run_frame(S7, SF, SBAD, SE);
        check_output("invalid_pulses", 32'(wv_cnt - wv0), 32'd1);
        check_output("invalid_word", 32'(wv_word), 32'h7F0E);
        check_output("invalid_err", 32'(wv_err), 32'b0010);

        // Multi-hot anode in the middle of a frame keeps digit 3's capture.
        wv0 = wv_cnt;
        hold_digit(4'b1000, SD, 10);
        hold_digit(4'b0000, 7'd0, 2);
        ae0 = ae_cnt;
        hold_digit(4'b0011, S8, 8);
        hold_digit(4'b0000, 7'd0, 4);
        check_output("anode_cycles", 32'(ae_cnt - ae0), 32'd8);
        check_output("anode_no_word", 32'(wv_cnt - wv0), 32'd0);
        hold_digit(4'b0100, S6, 10);
        hold_digit(4'b0010, S2, 10);
        hold_digit(4'b0001, S8, 10);
        hold_digit(4'b0000, 7'd0, 6);
        check_output("anode_pulses", 32'(wv_cnt - wv0), 32'd1);
        check_output("anode_word", 32'(wv_word), 32'hD628);

        // Partial frame discarded by timeout.
        wv0 = wv_cnt;
        to0 = to_cnt;
        hold_digit(4'b1000, S5, 10);
        hold_digit(4'b0100, S5, 10);
        hold_digit(4'b0000, 7'd0, 150);
        check_output("timeout_pulses", 32'(to_cnt - to0), 32'd1);
        check_output("timeout_no_word", 32'(wv_cnt - wv0), 32'd0);
        run_frame(S1, S2, S3, S4);
        check_output("timeout_next_pulses", 32'(wv_cnt - wv0), 32'd1);
        check_output("timeout_next_word", 32'(wv_word), 32'h1234);

        // Reset mid-frame wipes all partial captures.
        wv0 = wv_cnt;
        hold_digit(4'b1000, S8, 10);
        hold_digit(4'b0100, S8, 10);
        hold_digit(4'b0010, S8, 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold_digit(4'b0001, S8, 10);
        hold_digit(4'b0000, 7'd0, 10);
        check_output("rstmid_no_word", 32'(wv_cnt - wv0), 32'd0);
        check_output("rstmid_hex_word", 32'(hex_word), 32'h0);
        check_output("rstmid_digit_err", 32'(digit_err), 32'h0);
        check_output("rstmid_flags", 32'({word_valid, anode_err, timeout}), 32'h0);
        to0 = to_cnt;
        hold_digit(4'b0000, 7'd0, 110);
        check_output("rstmid_timeout", 32'(to_cnt - to0), 32'd1);
        run_frame(S5, S6, S7, S8);
        check_output("rstmid_next_pulses", 32'(wv_cnt - wv0), 32'd1);
        check_output("rstmid_next_word", 32'(wv_word), 32'h5678);
        check_output("rstmid_next_err", 32'(wv_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
